// File: rtl/mem_readback.sv
// Readback engine: streams a host-selected byte range out of memory over valid/ready,
// optionally closing the stream with a two's-complement checksum byte.
package mem_readback_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_t;
endpackage

// state | meaning
// IDLE  | waiting for start_i
// REQ   | memory read requested, address held until granted
// WAIT  | latency down-counter running, byte captured on terminal count
// SEND  | data byte presented on tx, waiting for sink
// CSUM  | checksum byte presented on tx
// DONE  | one-cycle completion pulse
module mem_readback
    import mem_readback_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 11,
    parameter int MEM_LATENCY = 1,
    parameter int APPEND_CSUM = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output mem_width_t        mem_width_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         data_q, data_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [7:0]         csum_neg;
    state_t             tail_state;
    logic               unused_data_hi;

    assign unused_data_hi = ^mem_data_i[31:8];
    assign tail_state     = (APPEND_CSUM != 0) ? S_CSUM : S_DONE;
    assign csum_neg       = 8'd0 - csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        data_d  = data_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = start_addr_i;
                    rem_d   = len_i;
                    csum_d  = '0;
                    state_d = (len_i != '0) ? S_REQ : tail_state;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    wait_d  = WAIT_W'(MEM_LATENCY);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Terminal count lands on the edge where the read data is valid.
                if (wait_q == WAIT_W'(1)) begin
                    data_d  = mem_data_i[7:0];
                    state_d = S_SEND;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    csum_d  = csum_q + data_q;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q > LEN_W'(1)) ? S_REQ : tail_state;
                end
            end
            S_CSUM: begin
                if (tx_ready_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        mem_req_o   = (state_q == S_REQ);
        mem_addr_o  = addr_q;
        mem_width_o = BYTE;
        mem_we_o    = 1'b0;
        tx_valid_o  = (state_q == S_SEND) || (state_q == S_CSUM);
        tx_data_o   = (state_q == S_CSUM) ? csum_neg : data_q;
    end

endmodule
